psi_member_stream: RTL and testbench



---
 rtl/psi_pkg.sv | 23 ++
 rtl/psi_lsb_finder.sv | 30 +++
 rtl/psi_member_stream.sv | 140 ++++++++++++++
 tb/tb_psi_member_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
// Shared PSI-side definitions: stream FSM states and index/count width helpers.
package psi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Width of an element index for a universe of n elements (never below 1).
   function automatic int unsigned psi_idx_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w == 0) ? 1 : w;
   endfunction

   // Width of a member count that must be able to hold n itself.
   function automatic int unsigned psi_cnt_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/psi_lsb_finder.sv
// Lowest-set-bit priority encoder with occupancy and single-bit flags.
module psi_lsb_finder
   import psi_pkg::*;
#(
   parameter  int unsigned b     = 10,
   localparam int unsigned IDX_W = psi_idx_w(b)
) (
   input  logic [b-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             one_hot_only
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int k = int'(b) - 1; k >= 0; k--) begin
         if (vec[k]) begin
            idx = IDX_W'(k);
         end
      end
   end

   // Occupancy flags used to decide the final beat.
   always_comb begin
      any          = |vec;
      one_hot_only = $onehot(vec);
   end

endmodule

// File: rtl/psi_member_stream.sv
// Streams the indices of set bits in a PSI membership mask, lowest first, and reports cardinality.
module psi_member_stream
   import psi_pkg::*;
#(
   parameter  int unsigned b     = 10,
   localparam int unsigned IDX_W = psi_idx_w(b),
   localparam int unsigned CNT_W = psi_cnt_w(b)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [b-1:0]     in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_empty,
   output logic             done,
   output logic [CNT_W-1:0] card
);

   state_t           r_state;
   logic [b-1:0]     r_work;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_out_last;
   logic             r_out_empty;
   logic             r_done;
   logic [CNT_W-1:0] r_card;

   state_t           w_state_nxt;
   logic [b-1:0]     w_work_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_card_nxt;
   logic             w_done_nxt;
   logic             w_fire;
   logic             w_emit_nxt;
   logic             w_in_ready_nxt;
   logic             w_out_valid_nxt;
   logic [IDX_W-1:0] w_out_idx_nxt;
   logic             w_out_last_nxt;
   logic             w_out_empty_nxt;

   logic [IDX_W-1:0] w_fnd_idx;
   logic             w_fnd_any;
   logic             w_fnd_one;

   // Beat outputs are precomputed from the next working value so they leave a register.
   psi_lsb_finder #(
      .b (b)
   ) u_finder (
      .vec          (w_work_nxt),
      .idx          (w_fnd_idx),
      .any          (w_fnd_any),
      .one_hot_only (w_fnd_one)
   );

   // Next-state, working mask, count and completion bookkeeping.
   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      w_card_nxt  = r_card;
      w_done_nxt  = 1'b0;
      w_fire      = r_out_valid & out_ready;

      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_work_nxt  = in_mask;
               w_cnt_nxt   = '0;
               w_state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (w_fire) begin
               // Clearing the lowest set bit retires the beat just accepted.
               w_work_nxt = r_work & (r_work - b'(1));
               if (!r_out_empty) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
               if (r_out_last) begin
                  w_state_nxt = IDLE;
                  w_card_nxt  = r_out_empty ? '0 : (r_cnt + CNT_W'(1));
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_emit_nxt      = (w_state_nxt == EMIT);
      w_in_ready_nxt  = ~w_emit_nxt;
      w_out_valid_nxt = w_emit_nxt;
      w_out_idx_nxt   = w_emit_nxt ? w_fnd_idx : '0;
      w_out_last_nxt  = w_emit_nxt & (w_fnd_one | ~w_fnd_any);
      w_out_empty_nxt = w_emit_nxt & ~w_fnd_any;
   end

   // State and output registers; reset discards any partial stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_work      <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_out_empty <= 1'b0;
         r_done      <= 1'b0;
         r_card      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_work      <= w_work_nxt;
         r_cnt       <= w_cnt_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_empty <= w_out_empty_nxt;
         r_done      <= w_done_nxt;
         r_card      <= w_card_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;
   assign out_empty = r_out_empty;
   assign done      = r_done;
   assign card      = r_card;

endmodule

// File: tb/tb_psi_member_stream.sv
// Scoreboard bench for psi_member_stream: stimulus pushes expected beats/cardinalities, a monitor checks them.
module tb_psi_member_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [9:0] in_mask = '0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_idx;
   logic       out_last;
   logic       out_empty;
   logic       done;
   logic [3:0] card;

   typedef struct packed {
      logic [3:0] idx;
      logic       last;
      logic       empty;
   } beat_t;

   beat_t      beat_q[$];
   int         card_q[$];
   int         total = 0;
   int         bad = 0;
   beat_t      mon_exp;
   logic       mon_stalled = 1'b0;
   logic [3:0] mon_stall_idx = '0;

   psi_member_stream #(
      .b (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_empty (out_empty),
      .done      (done),
      .card      (card)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_beat(input int idx, input bit last, input bit empty);
      beat_t e;
      e.idx   = 4'(idx);
      e.last  = last;
      e.empty = empty;
      beat_q.push_back(e);
   endfunction

   // Monitor: compares every accepted beat and every done pulse against the queues.
   always @(negedge clk) begin
      if (rst) begin
         mon_stalled = 1'b0;
      end else begin
         if (out_valid && mon_stalled)
            chk("hold_idx", int'(out_idx), int'(mon_stall_idx));
         if (out_valid && out_ready) begin
            chk("beat_expected", int'(beat_q.size() > 0), 1);
            if (beat_q.size() > 0) begin
               mon_exp = beat_q.pop_front();
               chk("beat_idx", int'(out_idx), int'(mon_exp.idx));
               chk("beat_last", int'(out_last), int'(mon_exp.last));
               chk("beat_empty", int'(out_empty), int'(mon_exp.empty));
            end
         end
         if (done) begin
            chk("done_expected", int'(card_q.size() > 0), 1);
            if (card_q.size() > 0)
               chk("card", int'(card), card_q.pop_front());
         end
         mon_stalled   = out_valid && !out_ready;
         mon_stall_idx = out_idx;
      end
   end

   // Offer a mask until accepted; called and returns at posedge+1.
   task automatic send(input logic [9:0] m);
      int c = 0;
      in_valid = 1'b1;
      in_mask  = m;
      while (!in_ready && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      chk("accept_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("first_beat_latency", int'(out_valid), 1);
   endtask

   // Run until all expectations are consumed; pat selects the 1,0,0 out_ready pattern.
   task automatic drain(input bit pat);
      int c = 0;
      while ((beat_q.size() != 0 || card_q.size() != 0) && c < 300) begin
         out_ready = pat ? (c % 3 == 0) : 1'b1;
         @(posedge clk); #1;
         c++;
      end
      chk("drain_pending", beat_q.size() + card_q.size(), 0);
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_empty", int'(out_empty), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_card", int'(card), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;

      // Sparse mask: 0, 2, 5
      push_beat(0, 0, 0); push_beat(2, 0, 0); push_beat(5, 1, 0);
      card_q.push_back(3);
      send(10'b0000100101);
      chk("t1_busy_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("t1_second_beat", int'(out_idx), 2);
      drain(1'b0);

      // Empty mask: single beat flagged out_empty
      push_beat(0, 1, 1);
      card_q.push_back(0);
      send(10'b0000000000);
      drain(1'b0);

      // Full mask with stalling downstream
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) push_beat(k, k == 9, 0);
      card_q.push_back(10);
      send(10'h3FF);
      drain(1'b1);

      // Back-to-back masks with in_valid held high
      push_beat(9, 1, 0);
      card_q.push_back(1);
      push_beat(0, 0, 0); push_beat(1, 1, 0);
      card_q.push_back(2);
      in_valid = 1'b1;
      in_mask  = 10'b1000000000;
      c = 0;
      while (!in_ready && c < 50) begin @(posedge clk); #1; c++; end
      @(posedge clk); #1;
      in_mask = 10'b0000000011;
      c = 0;
      while (!in_ready && c < 50) begin @(posedge clk); #1; c++; end
      chk("b2b_accept_in_done_cycle", int'(done), 1);
      chk("b2b_card_first", int'(card), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain(1'b0);

      // Reset while the second beat of 1,2,4 is presented
      push_beat(1, 0, 0);
      in_valid = 1'b1;
      in_mask  = 10'b0000010110;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_idx", int'(out_idx), 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_card", int'(card), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", int'(in_ready), 1);
      chk("post_rst_done", int'(done), 0);
      push_beat(0, 1, 0);
      card_q.push_back(1);
      send(10'b0000000001);
      drain(1'b0);

      // in_valid pulsed during EMIT must be ignored
      out_ready = 1'b0;
      push_beat(4, 0, 0); push_beat(6, 1, 0);
      card_q.push_back(2);
      send(10'b0001010000);
      in_valid = 1'b1;
      in_mask  = 10'h3FF;
      @(posedge clk); #1;
      chk("emit_in_ready", int'(in_ready), 0);
      chk("emit_idx_held", int'(out_idx), 4);
      in_valid = 1'b0;
      drain(1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("final_idle_in_ready", int'(in_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
